// File: rtl/hit_pkg.sv
// hit_pkg: shared defaults and arithmetic helpers for the hit-judging stage
package hit_pkg;
  localparam int DEF_NUM_HOLES = 18;
  function automatic int unsigned popcount(input logic [255:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 256; i++) n += 32'(v[i]);
    return n;
  endfunction
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b, input int unsigned lim);
    return (a > lim || b > lim - a) ? lim : a + b;
  endfunction
endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: 2-FF synchroniser, debounce filter and one-cycle toggle pulse for one switch
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic arm_i,
  input  logic sw_i,
  output logic toggle_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, stable_q, stable_d, tog_q, tog_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    s1_q <= sw_i;
    s2_q <= s1_q;
  end
  always_comb begin
    stable_d = stable_q;
    cnt_d = '0;
    tog_d = 1'b0;
    if (arm_i) stable_d = s2_q;
    else if (s2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = s2_q;
        tog_d = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q <= '0;
      tog_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      tog_q <= tog_d;
    end
  end
  assign toggle_o = tog_q;
endmodule

// File: rtl/hit_judge.sv
// hit_judge: debounced whack detection, round tracking and combo scoring
module hit_judge
  import hit_pkg::*;
#(
  parameter int NUM_HOLES = DEF_NUM_HOLES,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COMBO_W = 4,
  parameter int POINTS_W = 8,
  parameter int FULL_CLEAR_BONUS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic game_in_progress,
  input  logic [NUM_HOLES-1:0] mole_positions,
  input  logic [NUM_HOLES-1:0] switches,
  output logic [NUM_HOLES-1:0] LEDs,
  output logic miss,
  output logic non_full_clear_hit,
  output logic full_clear_hit,
  output logic [COMBO_W-1:0] combo,
  output logic [POINTS_W-1:0] hit_points
);
  localparam int unsigned CMAX = 32'((64'd1 << COMBO_W) - 64'd1);
  localparam int unsigned PMAX = 32'((64'd1 << POINTS_W) - 64'd1);
  logic [1:0] arm_q;
  logic arming, gip_q, load, judge, hit;
  logic miss_q, miss_d, nfc_q, nfc_d, full_q, full_d;
  logic [NUM_HOLES-1:0] tog, t_q, mp_q, mp_prev_q, up_q, up_d, hits, wrong, remain;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [POINTS_W-1:0] pts_q, pts_d;
  int unsigned base;
  assign arming = arm_q != 2'd3;
  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_sw
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
      .clk(clk),
      .reset(reset),
      .arm_i(arming),
      .sw_i(switches[i]),
      .toggle_o(tog[i])
    );
  end
  assign load = (mp_q != mp_prev_q) || (game_in_progress && !gip_q);
  assign judge = game_in_progress && !load && |t_q;
  assign hits = t_q & up_q;
  assign wrong = t_q & ~up_q;
  assign remain = up_q & ~hits;
  always_comb begin
    up_d = !game_in_progress ? '0 : load ? mp_q : judge ? remain : up_q;
    miss_d = judge && |wrong;
    full_d = judge && !(|wrong) && !(|remain);
    nfc_d = judge && !(|wrong) && |remain;
    hit = full_d || nfc_d;
    base = popcount(256'(hits)) * (32'(combo_q) + 32'd1);
    pts_d = hit ? POINTS_W'(sat_add(base, full_d ? 32'(FULL_CLEAR_BONUS) : 32'd0, PMAX)) : '0;
    combo_d = miss_d ? '0 : hit ? COMBO_W'(sat_add(32'(combo_q), 32'd1, CMAX)) : combo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q <= '0;
      t_q <= '0;
      mp_q <= '0;
      mp_prev_q <= '0;
      gip_q <= 1'b0;
      up_q <= '0;
      miss_q <= 1'b0;
      nfc_q <= 1'b0;
      full_q <= 1'b0;
      combo_q <= '0;
      pts_q <= '0;
    end else begin
      arm_q <= arming ? arm_q + 2'd1 : arm_q;
      t_q <= tog;
      mp_q <= mole_positions;
      mp_prev_q <= mp_q;
      gip_q <= game_in_progress;
      up_q <= up_d;
      miss_q <= miss_d;
      nfc_q <= nfc_d;
      full_q <= full_d;
      combo_q <= combo_d;
      pts_q <= pts_d;
    end
  end
  assign LEDs = up_q;
  assign miss = miss_q;
  assign non_full_clear_hit = nfc_q;
  assign full_clear_hit = full_q;
  assign combo = combo_q;
  assign hit_points = pts_q;
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: table-driven checks of whack judging, scoring, debounce, pause, reset and saturation
module tb_hit_judge;
  logic clk = 1'b0;
  logic reset, gip;
  logic [17:0] mp, sw;
  logic [17:0] leds_a, leds_b;
  logic miss_a, nfc_a, full_a, miss_b, nfc_b, full_b;
  logic [3:0] combo_a;
  logic [7:0] pts_a;
  logic [1:0] combo_b;
  logic [3:0] pts_b;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic [17:0] mp;
    logic [17:0] tgl;
    logic miss;
    logic nfc;
    logic full;
    int combo;
    int pts;
    logic [17:0] leds;
  } vec_t;
  vec_t tv[9];
  vec_t sv[6];
  hit_judge #(.NUM_HOLES(18), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .game_in_progress(gip), .mole_positions(mp), .switches(sw),
    .LEDs(leds_a), .miss(miss_a), .non_full_clear_hit(nfc_a), .full_clear_hit(full_a),
    .combo(combo_a), .hit_points(pts_a)
  );
  hit_judge #(.NUM_HOLES(18), .DEBOUNCE_CYCLES(4), .COMBO_W(2), .POINTS_W(4)) dut_s (
    .clk(clk), .reset(reset), .game_in_progress(gip), .mole_positions(mp), .switches(sw),
    .LEDs(leds_b), .miss(miss_b), .non_full_clear_hit(nfc_b), .full_clear_hit(full_b),
    .combo(combo_b), .hit_points(pts_b)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
    end
  endtask
  task automatic idle(input int n, output int p);
    p = 0;
    repeat (n) begin
      tick(1);
      if (miss_a | nfc_a | full_a | miss_b | nfc_b | full_b) p++;
    end
  endtask
  task automatic apply(input vec_t v, input bit sel, input int idx);
    int lat;
    if (mp !== v.mp) begin
      mp = v.mp;
      tick(3);
    end
    sw = sw ^ v.tgl;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (lat < 20 && !(sel ? (miss_b | nfc_b | full_b) : (miss_a | nfc_a | full_a)));
    chk("latency", idx, lat, 8);
    chk("miss", idx, sel ? miss_b : miss_a, v.miss);
    chk("non_full_clear_hit", idx, sel ? nfc_b : nfc_a, v.nfc);
    chk("full_clear_hit", idx, sel ? full_b : full_a, v.full);
    chk("combo", idx, sel ? 32'(combo_b) : 32'(combo_a), v.combo);
    chk("hit_points", idx, sel ? 32'(pts_b) : 32'(pts_a), v.pts);
    chk("leds", idx, sel ? leds_b : leds_a, v.leds);
    tick(1);
    chk("pulse_width", idx, sel ? {miss_b, nfc_b, full_b, 4'(pts_b)} : {miss_a, nfc_a, full_a, pts_a}, 0);
  endtask
  initial begin
    int p;
    tv[0] = '{mp: 18'h2A000, tgl: 18'h20000, miss: 0, nfc: 1, full: 0, combo: 1, pts: 1, leds: 18'h0A000};
    tv[1] = '{mp: 18'h2A000, tgl: 18'h08000, miss: 0, nfc: 1, full: 0, combo: 2, pts: 2, leds: 18'h02000};
    tv[2] = '{mp: 18'h2A000, tgl: 18'h02000, miss: 0, nfc: 0, full: 1, combo: 3, pts: 13, leds: 18'h0};
    tv[3] = '{mp: 18'h2A000, tgl: 18'h10000, miss: 1, nfc: 0, full: 0, combo: 0, pts: 0, leds: 18'h0};
    tv[4] = '{mp: 18'h38000, tgl: 18'h20001, miss: 1, nfc: 0, full: 0, combo: 0, pts: 0, leds: 18'h18000};
    tv[5] = '{mp: 18'h38000, tgl: 18'h10000, miss: 0, nfc: 1, full: 0, combo: 1, pts: 1, leds: 18'h08000};
    tv[6] = '{mp: 18'h38000, tgl: 18'h08000, miss: 0, nfc: 0, full: 1, combo: 2, pts: 12, leds: 18'h0};
    tv[7] = '{mp: 18'h00003, tgl: 18'h00003, miss: 0, nfc: 0, full: 1, combo: 3, pts: 16, leds: 18'h0};
    tv[8] = '{mp: 18'h0000F, tgl: 18'h00001, miss: 0, nfc: 1, full: 0, combo: 4, pts: 4, leds: 18'h0000E};
    sv[0] = '{mp: 18'h0001F, tgl: 18'h00001, miss: 0, nfc: 1, full: 0, combo: 1, pts: 1, leds: 18'h0001E};
    sv[1] = '{mp: 18'h0001F, tgl: 18'h00002, miss: 0, nfc: 1, full: 0, combo: 2, pts: 2, leds: 18'h0001C};
    sv[2] = '{mp: 18'h0001F, tgl: 18'h00004, miss: 0, nfc: 1, full: 0, combo: 3, pts: 3, leds: 18'h00018};
    sv[3] = '{mp: 18'h0001F, tgl: 18'h00008, miss: 0, nfc: 1, full: 0, combo: 3, pts: 4, leds: 18'h00010};
    sv[4] = '{mp: 18'h0001F, tgl: 18'h00010, miss: 0, nfc: 0, full: 1, combo: 3, pts: 14, leds: 18'h0};
    sv[5] = '{mp: 18'h00F00, tgl: 18'h00F00, miss: 0, nfc: 0, full: 1, combo: 3, pts: 15, leds: 18'h0};
    reset = 1'b1;
    gip = 1'b0;
    mp = '0;
    sw = 18'h3FFFF;
    tick(3);
    chk("reset_leds", 0, leds_a, 0);
    chk("reset_pulses", 0, {miss_a, nfc_a, full_a}, 0);
    chk("reset_combo", 0, combo_a, 0);
    chk("reset_points", 0, pts_a, 0);
    reset = 1'b0;
    gip = 1'b1;
    idle(30, p);
    chk("switches_up_silent", 0, p, 0);
    chk("switches_up_combo", 0, combo_a, 0);
    chk("switches_up_leds", 0, leds_a, 0);
    mp = 18'h2A000;
    tick(2);
    chk("round_latency", 0, leds_a, 18'h2A000);
    for (int i = 0; i < 9; i++) apply(tv[i], 1'b0, i);
    sw = sw ^ 18'h10000;
    tick(3);
    sw = sw ^ 18'h10000;
    idle(20, p);
    chk("bounce_silent", 0, p, 0);
    chk("bounce_leds", 0, leds_a, 18'h0000E);
    gip = 1'b0;
    tick(2);
    chk("pause_leds", 0, leds_a, 0);
    sw = sw ^ 18'h08000;
    idle(20, p);
    chk("pause_silent", 0, p, 0);
    chk("pause_combo_held", 0, combo_a, 4);
    gip = 1'b1;
    idle(20, p);
    chk("resume_silent", 0, p, 0);
    chk("resume_leds", 0, leds_a, 18'h0000F);
    reset = 1'b1;
    sw = sw ^ 18'h00020;
    tick(1);
    chk("midreset_leds", 0, leds_a, 0);
    chk("midreset_combo", 0, combo_a, 0);
    tick(5);
    reset = 1'b0;
    idle(30, p);
    chk("post_reset_silent", 0, p, 0);
    chk("post_reset_leds", 0, leds_a, 18'h0000F);
    chk("post_reset_combo", 0, combo_b, 0);
    for (int i = 0; i < 6; i++) apply(sv[i], 1'b1, 100 + i);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
